// File: rtl/rx_sync_monitor.sv
// ---------------------------------------------------------------------------
// rx_sync_monitor
//
// Purpose:
//   Sync qualification stage between the TVP sync input buffers and the RX
//   capture stage. Everything runs in the TVP_CLK domain. It does four jobs:
//   - re-times HS/VS by one clock and normalises them to active-high
//   - measures clocks per line (LINE_LEN)
//   - measures lines per frame (FRAME_LINES)
//   - runs a lock state machine. RX may only write the line buffer while
//     LOCKED is high.
//
// Handshake / signalling:
//   There is no valid/ready traffic here. LOCKED is a level qualifier for the
//   downstream write enable. LOST is a single-cycle event that lines up with
//   every 1->0 transition of LOCKED. Reset never produces a LOST pulse.
//
// Ports:
//   TVP_CLK      in   1        pixel clock from the TVP decoder
//   RST_N        in   1        asynchronous active-low reset
//   HS_IN        in   1        buffered TVP HSYNC, active level HS_POL
//   VS_IN        in   1        buffered TVP VSYNC, active level VS_POL
//   HS_OUT       out  1        HS_IN normalised to active-high, one clock late
//   VS_OUT       out  1        VS_IN normalised to active-high, one clock late
//   LINE_LEN     out  LINE_W   last measured clocks per line
//   FRAME_LINES  out  FRAME_W  last measured lines per frame
//   LOCKED       out  1        timing stable (RX write enable qualifier)
//   LOST         out  1        one-cycle pulse on LOCKED falling
//   DBG_STATE    out  2        lock FSM state: 0 SEARCH, 1 ACQUIRE, 2 LOCKED
// ---------------------------------------------------------------------------
module rx_sync_monitor #(
  parameter int LINE_W      = 12,
  parameter int FRAME_W     = 10,
  parameter int LINE_TOL    = 2,
  parameter int LOCK_FRAMES = 4,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1
) (
  input  logic               TVP_CLK,
  input  logic               RST_N,
  input  logic               HS_IN,
  input  logic               VS_IN,
  output logic               HS_OUT,
  output logic               VS_OUT,
  output logic [LINE_W-1:0]  LINE_LEN,
  output logic [FRAME_W-1:0] FRAME_LINES,
  output logic               LOCKED,
  output logic               LOST,
  output logic [1:0]         DBG_STATE
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam int SC_W = $clog2(LOCK_FRAMES + 1);

  localparam logic [LINE_W-1:0]  LINE_MAX    = '1;
  // One below saturation. Timeout fires here so that LOCKED drops exactly
  // 2^LINE_W-1 clocks after the edge that cleared the counter.
  localparam logic [LINE_W-1:0]  LINE_PRESAT = LINE_MAX - LINE_W'(1);
  localparam logic [FRAME_W-1:0] FRAME_MAX   = '1;
  localparam logic [LINE_W:0]    TOL         = (LINE_W + 1)'(LINE_TOL);
  localparam logic [SC_W-1:0]    LOCK_CNT    = SC_W'(LOCK_FRAMES);

  // -------------------------------------------------------------------------
  // Input re-timing and edge detection
  // -------------------------------------------------------------------------
  logic hs_norm;
  logic vs_norm;
  logic hs_q;
  logic hs_q2;
  logic vs_q;
  logic vs_q2;
  logic hs_edge;
  logic vs_edge;

  assign hs_norm = HS_POL ? HS_IN : ~HS_IN;
  assign vs_norm = VS_POL ? VS_IN : ~VS_IN;

  always_ff @(posedge TVP_CLK or negedge RST_N) begin
    if (!RST_N) begin
      hs_q  <= 1'b0;
      hs_q2 <= 1'b0;
      vs_q  <= 1'b0;
      vs_q2 <= 1'b0;
    end else begin
      hs_q  <= hs_norm;
      hs_q2 <= hs_q;
      vs_q  <= vs_norm;
      vs_q2 <= vs_q;
    end
  end

  // The edges are seen one clock after the input changes. That is the same
  // cycle in which HS_OUT/VS_OUT first show the active level.
  assign hs_edge = hs_q & ~hs_q2;
  assign vs_edge = vs_q & ~vs_q2;

  assign HS_OUT = hs_q;
  assign VS_OUT = vs_q;

  // -------------------------------------------------------------------------
  // Line measurement
  // -------------------------------------------------------------------------
  logic [LINE_W-1:0]  line_cnt;
  logic [LINE_W-1:0]  line_len;
  logic [LINE_W-1:0]  line_next_len;
  logic               line_sat;
  logic signed [LINE_W:0] line_diff;
  logic [LINE_W:0]    line_abs;
  logic               line_ok;
  logic               first_line;
  logic               timeout;

  assign line_sat      = (line_cnt == LINE_MAX);
  assign line_next_len = line_cnt + LINE_W'(1);

  // The delta is computed one bit wider and signed. This way a large
  // positive or negative step cannot wrap into the tolerance window.
  assign line_diff = $signed({1'b0, line_next_len}) - $signed({1'b0, line_len});
  assign line_abs  = line_diff[LINE_W] ? $unsigned(-line_diff) : $unsigned(line_diff);

  // A line that ran into saturation has no valid length. It never counts as
  // stable, except as the first line after SEARCH.
  assign line_ok = first_line | (~line_sat & (line_abs <= TOL));

  // Timeout holds as a level while no HSYNC arrives. This lets a stalled
  // source also pull ACQUIRE back to SEARCH.
  assign timeout = ~hs_edge & (line_cnt >= LINE_PRESAT);

  always_ff @(posedge TVP_CLK or negedge RST_N) begin
    if (!RST_N) begin
      line_cnt <= '0;
      line_len <= '0;
    end else if (hs_edge) begin
      line_cnt <= '0;
      // A saturated count would be a false measurement, so the last good
      // value is kept instead.
      if (!line_sat) begin
        line_len <= line_next_len;
      end
    end else if (!line_sat) begin
      line_cnt <= line_next_len;
    end
  end

  assign LINE_LEN = line_len;

  // -------------------------------------------------------------------------
  // Frame measurement
  // -------------------------------------------------------------------------
  logic [FRAME_W-1:0] frame_cnt;
  logic [FRAME_W-1:0] frame_lines;
  logic [FRAME_W-1:0] frame_cnt_hs;
  logic               frame_bad;
  logic               frame_bad_now;
  logic               first_frame;
  logic               frame_ok;

  // An hs_edge is folded into the running count before any frame close in
  // the same cycle. A line whose HSYNC coincides with VSYNC therefore belongs
  // to the frame that is ending.
  assign frame_cnt_hs = (hs_edge && (frame_cnt != FRAME_MAX)) ?
                        frame_cnt + FRAME_W'(1) : frame_cnt;

  assign frame_bad_now = frame_bad | (hs_edge & ~line_ok);

  // The first frame closed after SEARCH has no trusted predecessor. For that
  // frame only the per-line stability is considered.
  assign frame_ok = (first_frame | (frame_cnt_hs == frame_lines)) & ~frame_bad_now;

  always_ff @(posedge TVP_CLK or negedge RST_N) begin
    if (!RST_N) begin
      frame_cnt   <= '0;
      frame_lines <= '0;
      frame_bad   <= 1'b0;
    end else if (vs_edge) begin
      frame_cnt   <= '0;
      frame_lines <= frame_cnt_hs;
      frame_bad   <= 1'b0;
    end else begin
      frame_cnt   <= frame_cnt_hs;
      frame_bad   <= frame_bad_now;
    end
  end

  assign FRAME_LINES = frame_lines;

  // -------------------------------------------------------------------------
  // "First after SEARCH" markers
  // -------------------------------------------------------------------------
  state_t state;
  state_t next_state;

  always_ff @(posedge TVP_CLK or negedge RST_N) begin
    if (!RST_N) begin
      first_line  <= 1'b0;
      first_frame <= 1'b0;
    end else begin
      if (state == ST_SEARCH) begin
        first_line <= 1'b1;
      end else if (hs_edge) begin
        first_line <= 1'b0;
      end
      if (state == ST_SEARCH) begin
        first_frame <= 1'b1;
      end else if (vs_edge) begin
        first_frame <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Lock state machine
  // -------------------------------------------------------------------------
  logic [SC_W-1:0] stable_cnt;
  logic [SC_W-1:0] stable_next;
  logic [SC_W-1:0] stable_inc;
  logic            fault;

  assign stable_inc = stable_cnt + SC_W'(1);
  assign fault      = timeout | (hs_edge & ~line_ok) | (vs_edge & ~frame_ok);

  always_ff @(posedge TVP_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_SEARCH;
      stable_cnt <= '0;
    end else begin
      state      <= next_state;
      stable_cnt <= stable_next;
    end
  end

  always_comb begin
    next_state  = state;
    stable_next = stable_cnt;
    case (state)
      ST_SEARCH: begin
        stable_next = '0;
        if (vs_edge && !timeout) begin
          next_state = ST_ACQUIRE;
        end
      end
      ST_ACQUIRE: begin
        if (timeout) begin
          next_state  = ST_SEARCH;
          stable_next = '0;
        end else if (vs_edge) begin
          if (frame_ok) begin
            stable_next = stable_inc;
            if (stable_inc >= LOCK_CNT) begin
              next_state = ST_LOCKED;
            end
          end else begin
            stable_next = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (fault) begin
          next_state  = ST_SEARCH;
          stable_next = '0;
        end
      end
      default: begin
        next_state  = ST_SEARCH;
        stable_next = '0;
      end
    endcase
  end

  // LOCKED and LOST are registered from the same next-state decision. This
  // keeps the LOST pulse aligned with the cycle in which LOCKED goes low.
  always_ff @(posedge TVP_CLK or negedge RST_N) begin
    if (!RST_N) begin
      LOCKED <= 1'b0;
      LOST   <= 1'b0;
    end else begin
      LOCKED <= (next_state == ST_LOCKED);
      LOST   <= (state == ST_LOCKED) && (next_state != ST_LOCKED);
    end
  end

  assign DBG_STATE = state;

endmodule

// File: tb/tb_rx_sync_monitor.sv
// ---------------------------------------------------------------------------
// tb_rx_sync_monitor
//
// Directed bench for rx_sync_monitor. It uses short lines (40 clocks) and
// short frames (10 lines) so that lock and relock fit in a few thousand
// cycles. LINE_W stays at 12, so the 4095-clock HSYNC timeout is exercised
// for real.
// ---------------------------------------------------------------------------
module tb_rx_sync_monitor;

  localparam int LINE_W  = 12;
  localparam int FRAME_W = 10;
  localparam int LEN     = 40;
  localparam int NLINES  = 10;

  localparam logic [31:0] S_SEARCH  = 32'd0;
  localparam logic [31:0] S_ACQUIRE = 32'd1;
  localparam logic [31:0] S_LOCKED  = 32'd2;

  logic               clk;
  logic               rst_n;
  logic               hs_in;
  logic               vs_in;
  logic               hs_out;
  logic               vs_out;
  logic [LINE_W-1:0]  line_len;
  logic [FRAME_W-1:0] frame_lines;
  logic               locked;
  logic               lost;
  logic [1:0]         dbg_state;

  int total;
  int bad;
  int lost_cnt;

  rx_sync_monitor #(
    .LINE_W      (LINE_W),
    .FRAME_W     (FRAME_W),
    .LINE_TOL    (2),
    .LOCK_FRAMES (4),
    .HS_POL      (1'b1),
    .VS_POL      (1'b1)
  ) dut (
    .TVP_CLK     (clk),
    .RST_N       (rst_n),
    .HS_IN       (hs_in),
    .VS_IN       (vs_in),
    .HS_OUT      (hs_out),
    .VS_OUT      (vs_out),
    .LINE_LEN    (line_len),
    .FRAME_LINES (frame_lines),
    .LOCKED      (locked),
    .LOST        (lost),
    .DBG_STATE   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Counts LOST pulses, sampled away from the active edge.
  initial lost_cnt = 0;
  always @(negedge clk) begin
    if (lost === 1'b1) lost_cnt++;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One line of len clocks. HS is high for the first 4 clocks. VS goes high
  // together with HS when this line opens a frame.
  task automatic drive_line(input int len, input bit with_vs, input int start);
    for (int i = start; i < len; i++) begin
      hs_in = (i < 4);
      vs_in = with_vs && (i < 4);
      tick();
    end
  endtask

  task automatic drive_frame(input int nlines, input int len);
    drive_line(len, 1'b1, 0);
    for (int l = 1; l < nlines; l++) drive_line(len, 1'b0, 0);
  endtask

  // Opens a frame and stops after two clocks. The first clock registers the
  // edges; the second is the clock on which the FSM reacts.
  task automatic open_frame_two_clks();
    hs_in = 1'b1;
    vs_in = 1'b1;
    tick();
    tick();
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    hs_in = 1'b0;
    vs_in = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_hs_out", hs_out, 0);
    check("rst_vs_out", vs_out, 0);
    check("rst_line_len", line_len, 0);
    check("rst_frame_lines", frame_lines, 0);
    check("rst_locked", locked, 0);
    check("rst_lost", lost, 0);
    check("rst_state", dbg_state, S_SEARCH);

    rst_n = 1'b1;
    tick();

    // 1. Nominal. The first vs_edge enters ACQUIRE; LOCKED rises one clock
    //    after the 5th vs_edge.
    for (int f = 0; f < 4; f++) drive_frame(NLINES, LEN);
    check("nom_state_acq", dbg_state, S_ACQUIRE);
    check("nom_unlocked_4", locked, 0);
    hs_in = 1'b1;
    vs_in = 1'b1;
    tick();
    check("nom_hs_out", hs_out, 1);
    check("nom_vs_out", vs_out, 1);
    check("nom_locked_edge_clk", locked, 0);
    tick();
    check("nom_locked", locked, 1);
    check("nom_state_locked", dbg_state, S_LOCKED);
    check("nom_line_len", line_len, LEN);
    check("nom_frame_lines", frame_lines, NLINES);
    drive_line(LEN, 1'b1, 2);
    for (int l = 1; l < NLINES; l++) drive_line(LEN, 1'b0, 0);

    // 2. Jitter of +-1 around 40 (steps of 2) keeps lock.
    drive_line(LEN, 1'b1, 0);
    for (int l = 1; l < NLINES; l++) drive_line((l % 2) ? 41 : 39, 1'b0, 0);
    drive_line(LEN, 1'b1, 0);
    check("jit_locked", locked, 1);
    check("jit_no_lost", lost_cnt, 0);
    check("jit_line_len", line_len, 41);
    // A 44-clock line after a 40-clock one is a step of 4.
    drive_line(44, 1'b0, 0);
    hs_in = 1'b1;
    vs_in = 1'b0;
    tick();
    check("spike_locked_pre", locked, 1);
    tick();
    check("spike_locked_fall", locked, 0);
    check("spike_lost", lost, 1);
    check("spike_state", dbg_state, S_SEARCH);
    check("spike_line_len", line_len, 44);
    tick();
    check("spike_lost_one_clk", lost, 0);
    drive_line(LEN, 1'b0, 3);
    for (int l = 3; l < NLINES; l++) drive_line(LEN, 1'b0, 0);
    for (int f = 0; f < 4; f++) drive_frame(NLINES, LEN);
    check("relock1_not_yet", locked, 0);
    open_frame_two_clks();
    check("relock1_locked", locked, 1);
    check("relock1_lost_total", lost_cnt, 1);
    drive_line(LEN, 1'b1, 2);
    for (int l = 1; l < NLINES; l++) drive_line(LEN, 1'b0, 0);

    // 3. A frame that is one line short drops lock, then the bench relocks.
    drive_frame(NLINES - 1, LEN);
    open_frame_two_clks();
    check("short_locked", locked, 0);
    check("short_lost", lost, 1);
    check("short_frame_lines", frame_lines, NLINES - 1);
    check("short_state", dbg_state, S_SEARCH);
    drive_line(LEN, 1'b1, 2);
    for (int l = 1; l < NLINES; l++) drive_line(LEN, 1'b0, 0);
    for (int f = 0; f < 4; f++) drive_frame(NLINES, LEN);
    check("relock2_not_yet", locked, 0);
    check("relock2_state_acq", dbg_state, S_ACQUIRE);
    open_frame_two_clks();
    check("relock2_locked", locked, 1);
    // 5. HS and VS rise together, so that line belongs to the closing frame.
    check("same_clk_frame_lines", frame_lines, NLINES);
    check("relock2_lost_total", lost_cnt, 2);

    // 4. HSYNC removed. The line counter was cleared on the 2nd clock above.
    //    LOCKED must hold for 4094 more clocks and fall on the 4095th.
    for (int i = 2; i <= 4095; i++) begin
      hs_in = (i < 4);
      vs_in = (i < 4);
      tick();
    end
    check("tmo_locked_hold", locked, 1);
    hs_in = 1'b0;
    vs_in = 1'b0;
    tick();
    check("tmo_locked_fall", locked, 0);
    check("tmo_lost", lost, 1);
    check("tmo_state", dbg_state, S_SEARCH);
    check("tmo_line_len", line_len, LEN);
    drive_line(LEN, 1'b0, 0);
    check("tmo_len_after_resume", line_len, LEN);
    check("tmo_lost_total", lost_cnt, 3);
    for (int f = 0; f < 4; f++) drive_frame(NLINES, LEN);
    open_frame_two_clks();
    check("relock3_locked", locked, 1);
    drive_line(LEN, 1'b1, 2);
    for (int l = 1; l < 3; l++) drive_line(LEN, 1'b0, 0);

    // 6. Asynchronous reset mid-frame while locked.
    #2;
    rst_n = 1'b0;
    hs_in = 1'b0;
    vs_in = 1'b0;
    #1;
    check("arst_locked", locked, 0);
    check("arst_lost", lost, 0);
    check("arst_line_len", line_len, 0);
    check("arst_frame_lines", frame_lines, 0);
    check("arst_hs_out", hs_out, 0);
    check("arst_state", dbg_state, S_SEARCH);
    repeat (3) tick();
    check("arst_hold_lost", lost, 0);
    rst_n = 1'b1;
    tick();
    drive_line(LEN, 1'b0, 0);
    drive_line(LEN, 1'b0, 0);
    check("post_rst_search", dbg_state, S_SEARCH);
    for (int f = 0; f < 4; f++) drive_frame(NLINES, LEN);
    check("post_rst_not_yet", locked, 0);
    open_frame_two_clks();
    check("post_rst_locked", locked, 1);
    check("post_rst_lost_total", lost_cnt, 3);
    hs_in = 1'b0;
    vs_in = 1'b0;
    tick();

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
